// File: rtl/serial_frame_rx_if.sv
// Byte-level and line-level signals between the serial transmitter/consumer and serial_frame_rx.
interface serial_frame_rx_if;
    logic       serial_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       dsr;
    logic       frame_err;
    logic       overrun;
    logic [7:0] frame_cnt;

    modport master (
        output serial_in, rx_ack,
        input  rx_data, rx_valid, dsr, frame_err, overrun, frame_cnt
    );

    modport slave (
        input  serial_in, rx_ack,
        output rx_data, rx_valid, dsr, frame_err, overrun, frame_cnt
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Decodes the one-cycle-per-bit pulse serial line into bytes with a valid/ack holding register.
module serial_frame_rx #(
    parameter int BIT_PERIOD = 106,
    parameter int CNT_W      = 10
) (
    input  logic               clock,
    input  logic               reset,
    serial_frame_rx_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] PERIOD = CNT_W'(BIT_PERIOD);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             stop_good, stop_bad;
    logic             accept, drop;

    logic             sample;
    assign sample = (cnt == PERIOD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.serial_in) begin
                    cnt_nxt     = CNT_W'(1);
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    // MSB arrives first, so shifting left leaves it in bit 7
                    shreg_nxt   = {shreg[6:0], bus.serial_in};
                    cnt_nxt     = CNT_W'(1);
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (sample) begin
                    // Back to IDLE on the stop edge; a low stop bit is not a new start
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    stop_good = bus.serial_in;
                    stop_bad  = !bus.serial_in;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = stop_good && (!bus.rx_valid || bus.rx_ack);
    assign drop   = stop_good && bus.rx_valid && !bus.rx_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.frame_cnt <= '0;
        end else begin
            bus.frame_err <= stop_bad;
            bus.overrun   <= drop;
            if (accept) begin
                bus.rx_data   <= shreg;
                bus.rx_valid  <= 1'b1;
                bus.frame_cnt <= bus.frame_cnt + 8'd1;
            end else if (bus.rx_ack) begin
                bus.rx_valid  <= 1'b0;
            end
        end
    end

    assign bus.dsr = (state == IDLE) && !bus.rx_valid;
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receiver stage placed directly downstream of the ADC-sequencer/serial-transmitter block. It decodes that block's pulse-style serial line into bytes and hands each byte to the consumer through a valid/ack holding register. It also drives back the `dsr` readiness level the transmitter samples before sending. On the line, idle is high and each bit (start, 8 data bits MSB first, stop) is presented for exactly one clock cycle, once every `BIT_PERIOD` cycles.

## Interface
- `BIT_PERIOD`, 106, clock cycles between successive bit cycles on `serial_in`; legal range 2..2^`CNT_W`-1.
- `CNT_W`, 10, width of the bit-period counter.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `serial_in` input 1: serial line from the transmitter's `data_out`.
- `rx_ack` input 1: consumer acknowledges the held byte.
- `rx_data` output 8: last accepted byte.
- `rx_valid` output 1: `rx_data` holds an unacknowledged byte.
- `dsr` output 1: receiver ready; to the transmitter's `dsr` input.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a good frame is dropped because the held byte was not acknowledged.
- `frame_cnt` output 8: count of accepted frames; wraps 255→0.

## Operation
- **Reset values:** state=IDLE, counter=0, shift register=0, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `frame_cnt`=0. `dsr` is therefore 1.
- **`dsr`** is combinational: (state==IDLE) && !`rx_valid`.
- **IDLE:**
  - `serial_in`==0 on an edge is a start bit: counter←1, bit index←0, go to DATA.
  - `serial_in`==1: stay in IDLE.
- **DATA:**
  - Counter increments each cycle.
  - When counter==`BIT_PERIOD`, sample `serial_in` into the shift register LSB (shift left, so the first data bit ends in bit 7), counter←1, bit index+1.
  - After the 8th sample, go to STOP.
- **STOP:**
  - Counter increments. When counter==`BIT_PERIOD`, sample the stop bit and return to IDLE on the same edge.
  - **Stop==1 and (`rx_valid`==0 or `rx_ack`==1):** `rx_data`←shift register, `rx_valid`←1, `frame_cnt`+1.
  - **Stop==1 and `rx_valid`==1 and `rx_ack`==0:** byte discarded, `rx_data` unchanged, `overrun` pulses, `frame_cnt` unchanged.
  - **Stop==0:** byte discarded, `frame_err` pulses, nothing else changes. This low cycle is not re-interpreted as a start bit.
- **Handshake:**
  - `rx_ack` while `rx_valid`==1 clears `rx_valid` at that edge, unless a good frame completes on the same edge; then the new byte loads and `rx_valid` stays 1.
  - `rx_ack` while `rx_valid`==0 is ignored.
- `serial_in` is not checked between sample points; the line is expected high there.
- Arithmetic: counter is `CNT_W` bits and never exceeds `BIT_PERIOD`. Bit index is 3 bits plus the state. `frame_cnt` is modulo 256.

## Timing
- Start bit seen at edge T (`serial_in` low in the cycle before T).
- Data bit k (k=0..7, MSB first) is sampled at edge T+(k+1)·`BIT_PERIOD`.
- Stop bit is sampled at edge T+9·`BIT_PERIOD`; `rx_valid`/`rx_data`/`frame_err`/`overrun` change at that edge.
- The earliest next start bit is accepted at edge T+9·`BIT_PERIOD`+1.
- Pulses (`frame_err`, `overrun`) are high for exactly one cycle.
- `dsr` drops in the cycle after T and returns after the stop edge only if `rx_valid` is 0.
- Reset asserted mid-frame aborts immediately: no `rx_valid`, pulse or count change. The first edge after deassertion behaves as IDLE.

## Test plan
- Reset, then send frame 0xA5 with `BIT_PERIOD`=106, starting at edge T: `rx_data`=0xA5, `rx_valid`=1 after edge T+954, `frame_cnt`=1, `dsr` 0 during the frame and still 0 until `rx_ack`, then 1.
- Frame 0x3C with stop bit driven 0: `frame_err` pulses at edge T+954, `rx_valid` stays 0, `frame_cnt` unchanged, IDLE afterwards.
- Receive 0x11, no ack, then receive 0x22: `overrun` pulses, `rx_data` stays 0x11, `frame_cnt`=1. Then ack with `rx_ack` and receive 0x22: `rx_data`=0x22, `frame_cnt`=2.
- Hold 0x55, assert `rx_ack` exactly on the stop edge of frame 0xAA: `rx_data`=0xAA, `rx_valid` stays 1, no `overrun`.
- Assert `reset` at T+500 mid-frame: all outputs return to reset values immediately. A fresh frame 0xFF afterwards decodes as 0xFF with `frame_cnt`=1.
- Send 256 good frames, acking each: `frame_cnt` wraps to 0, no error pulses.
